// File: rtl/pc_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and instruction memory (slave).
interface pc_fetch_stage_if #(
  parameter int unsigned IMEM_ADDR_W = 10
);
  logic                   imem_req;
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic                   imem_ack;
  logic [31:0]            imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_stage.sv
// PC holder and FETCH/EXEC/HALT sequencer for the multi-cycle MIPS core.
// Optional statistics counters are built only when PC_STATS_EN is defined.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             pc_next,
  input  logic                    branch_sig,
  input  logic                    branched,
  input  logic                    stall,
  input  logic                    halt,
  input  logic                    go,
  pc_fetch_stage_if.master        imem,
  output logic [31:0]             pc,
  output logic [31:0]             pc_plus_four,
  output logic [31:0]             instr,
  output logic                    instr_valid,
  output logic                    halted,
  output logic [31:0]             cycle_cnt,
  output logic [31:0]             retire_cnt,
  output logic [31:0]             branch_cnt,
  output logic [31:0]             taken_cnt
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        retire_s;
  logic [31:0] pc_plus_four_s;
  logic        unused_s;

  assign pc_plus_four_s = pc_q + 32'd4;
  assign unused_s       = ^pc_next[1:0];

  // Next-state, next-PC and registered-output decode.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    retire_s = 1'b0;
    case (state_q)
      ST_FETCH: begin
        // req_q gates ack so the cycle just after reset release never accepts data.
        if (req_q && imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (stall) begin
          state_d = ST_EXEC;
        end else if (halt) begin
          pc_d     = pc_plus_four_s;
          state_d  = ST_HALT;
          retire_s = 1'b1;
        end else begin
          pc_d     = {pc_next[31:2], 2'b00};
          state_d  = ST_FETCH;
          retire_s = 1'b1;
        end
      end
      ST_HALT: begin
        if (go) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
    req_d    = (state_d == ST_FETCH);
    valid_d  = (state_d == ST_EXEC);
    halted_d = (state_d == ST_HALT);
  end

  // State, PC, instruction and decoded-output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= 32'd0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q[IMEM_ADDR_W+1:2];
  assign pc             = pc_q;
  assign pc_plus_four   = pc_plus_four_s;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign halted         = halted_q;

`ifdef PC_STATS_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) begin
      return v + 32'd1;
    end else begin
      return v;
    end
  endfunction

  // Saturating statistics increments.
  always_comb begin
    cycle_cnt_d  = sat_inc(cycle_cnt_q, state_q != ST_HALT);
    retire_cnt_d = sat_inc(retire_cnt_q, retire_s);
    branch_cnt_d = sat_inc(branch_cnt_q, retire_s & branch_sig);
    taken_cnt_d  = sat_inc(taken_cnt_q, retire_s & branched);
  end

  // Statistics counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q  <= 32'd0;
      retire_cnt_q <= 32'd0;
      branch_cnt_q <= 32'd0;
      taken_cnt_q  <= 32'd0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign cycle_cnt  = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;
  assign branch_cnt = branch_cnt_q;
  assign taken_cnt  = taken_cnt_q;
`else
  logic stats_unused_s;

  assign stats_unused_s = branch_sig ^ branched ^ retire_s;
  assign cycle_cnt      = 32'd0;
  assign retire_cnt     = 32'd0;
  assign branch_cnt     = 32'd0;
  assign taken_cnt      = 32'd0;
`endif

endmodule
